// File: rtl/binary_projection_counter.sv
// Row/column foreground projection of one thresholded frame in the pixel clock domain.
// Arm, clear, sync to a frame start, accumulate one frame, then hold results for readback.
module binary_projection_counter #(
  parameter int   H_ACTIVE = 640,
  parameter int   V_ACTIVE = 480,
  parameter int   CNT_W    = 10,
  parameter logic FG_LEVEL = 1'b1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic             iPIXEL,
  input  logic [8:0]       iROW_ADDR,
  input  logic [9:0]       iCOL_ADDR,
  output logic [CNT_W-1:0] oROW_CNT,
  output logic [CNT_W-1:0] oCOL_CNT,
  output logic [19:0]      oTOTAL,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oSHORT,
  output logic [2:0]       oSTATE
);

  // state     | meaning
  // IDLE      | inactive, waiting for iSTART
  // CLEAR     | zeroing both projection RAMs, one entry per cycle
  // WAIT_LOW  | waiting for frame blanking so a partial frame is never counted
  // WAIT_RISE | waiting for frame start; a pixel on the rising cycle is counted
  // ACCUM     | counting pixels until V_ACTIVE lines or an early frame end
  // FLUSH     | last column write drains; reported to the LEDs as ACCUM
  // DONE      | results frozen and readable; iSTART re-arms
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_ACCUM     = 3'd4,
    S_DONE      = 3'd5,
    S_FLUSH     = 3'd6
  } state_t;

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int YC = YW + 1;
  localparam logic [XW-1:0]    X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0]    ROW_CLR = XW'(V_ACTIVE);
  localparam logic [YC-1:0]    Y_LAST  = YC'(V_ACTIVE - 1);
  localparam logic [YC-1:0]    Y_END   = YC'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state, state_nx;

  logic [CNT_W-1:0] col_mem [H_ACTIVE];
  logic [CNT_W-1:0] row_mem [V_ACTIVE];

  logic [XW-1:0]    idx, x, p_addr;
  logic [YC-1:0]    y;
  logic [CNT_W-1:0] acc, acc_nx, col_rd, col_wr, row_q, col_q;
  logic             p_valid, p_fg;
  logic             fg, y_full, pix_en, line_end, frame_end, short_exit;

  assign fg         = (iPIXEL == FG_LEVEL);
  assign y_full     = (y == Y_END);
  assign pix_en     = iDVAL && (((state == S_ACCUM) && !y_full) ||
                                ((state == S_WAIT_RISE) && iFVAL));
  assign line_end   = pix_en && (x == X_LAST);
  assign frame_end  = line_end && (y == Y_LAST);
  // The final pixel wins over a simultaneous frame-valid drop: the frame is complete.
  assign short_exit = (state == S_ACCUM) && !y_full && !iFVAL && !frame_end;
  assign acc_nx     = (pix_en && fg && (acc != CNT_MAX)) ? acc + CNT_ONE : acc;
  assign col_wr     = (p_fg && (col_rd != CNT_MAX)) ? col_rd + CNT_ONE : col_rd;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    oBUSY    = 1'b0;
    oDONE    = 1'b0;
    oSTATE   = state;
    case (state)
      S_IDLE:      if (iSTART) state_nx = S_CLEAR;
      S_CLEAR: begin
        oBUSY = 1'b1;
        if (idx == X_LAST) state_nx = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        oBUSY = 1'b1;
        if (!iFVAL) state_nx = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        oBUSY = 1'b1;
        if (iFVAL) state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        oBUSY = 1'b1;
        if (y_full || short_exit) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        oBUSY    = 1'b1;
        oSTATE   = S_ACCUM;
        state_nx = S_DONE;
      end
      S_DONE: begin
        oDONE = 1'b1;
        if (iSTART) state_nx = S_CLEAR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      idx     <= '0;
      x       <= '0;
      y       <= '0;
      acc     <= '0;
      oTOTAL  <= '0;
      oSHORT  <= 1'b0;
      p_valid <= 1'b0;
      p_fg    <= 1'b0;
      p_addr  <= '0;
    end else begin
      p_valid <= pix_en;
      p_fg    <= fg;
      p_addr  <= x;
      idx     <= (state == S_CLEAR) ? idx + 1'b1 : '0;
      if (state == S_CLEAR) begin
        x      <= '0;
        y      <= '0;
        acc    <= '0;
        oTOTAL <= '0;
        oSHORT <= 1'b0;
      end else if (pix_en) begin
        oTOTAL <= oTOTAL + 20'(fg);
        if (line_end) begin
          x   <= '0;
          y   <= y + 1'b1;
          acc <= '0;
        end else begin
          x   <= x + 1'b1;
          acc <= acc_nx;
        end
      end
      if (short_exit) oSHORT <= 1'b1;
    end
  end

  // RAM ports: column read-modify-write pipeline plus one registered HPS read per RAM.
  always_ff @(posedge iCLK) begin
    col_rd <= col_mem[x];
    col_q  <= (iCOL_ADDR < 10'(H_ACTIVE)) ? col_mem[iCOL_ADDR[XW-1:0]] : '0;
    row_q  <= (iROW_ADDR < 9'(V_ACTIVE))  ? row_mem[iROW_ADDR[YW-1:0]] : '0;
    if (state == S_CLEAR)  col_mem[idx]    <= '0;
    else if (p_valid)      col_mem[p_addr] <= col_wr;
    if (state == S_CLEAR) begin
      if (idx < ROW_CLR) row_mem[idx[YW-1:0]] <= '0;
    end else if (line_end || short_exit) begin
      row_mem[y[YW-1:0]] <= acc_nx;
    end
  end

  assign oROW_CNT = (state == S_DONE) ? row_q : '0;
  assign oCOL_CNT = (state == S_DONE) ? col_q : '0;

endmodule

// File: tb/tb_binary_projection_counter.sv
// Directed bench for binary_projection_counter on a reduced 32x24 frame, plus a
// narrow-count instance sharing the same stimulus to exercise saturation.
module tb_binary_projection_counter;
  localparam int H = 32;
  localparam int V = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, fval, dval, pixel;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [9:0]  row_cnt, col_cnt;
  logic [19:0] total;
  logic        busy, done, short_f;
  logic [2:0]  state;
  logic [3:0]  s_row, s_col;
  logic [19:0] s_total;
  logic        s_busy, s_done, s_short;
  logic [2:0]  s_state;

  binary_projection_counter #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(10), .FG_LEVEL(1'b1)) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iFVAL(fval), .iDVAL(dval), .iPIXEL(pixel),
    .iROW_ADDR(row_addr), .iCOL_ADDR(col_addr), .oROW_CNT(row_cnt), .oCOL_CNT(col_cnt),
    .oTOTAL(total), .oBUSY(busy), .oDONE(done), .oSHORT(short_f), .oSTATE(state));

  binary_projection_counter #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(4), .FG_LEVEL(1'b1)) dut_sat (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iFVAL(fval), .iDVAL(dval), .iPIXEL(pixel),
    .iROW_ADDR(row_addr), .iCOL_ADDR(col_addr), .oROW_CNT(s_row), .oCOL_CNT(s_col),
    .oTOTAL(s_total), .oBUSY(s_busy), .oDONE(s_done), .oSHORT(s_short), .oSTATE(s_state));

  typedef struct {
    int row_addr;
    int col_addr;
    int exp_row;
    int exp_col;
  } rd_vec_t;

  rd_vec_t tab_full[5];
  rd_vec_t tab_short[6];
  int tests = 0;
  int fails = 0;
  int mrow[V];
  int mcol[H];
  int mtot;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic bit pat(input int kind, input int x, input int y);
    case (kind)
      0:       return 1'b1;
      1:       return (x == 17) && (y == 20);
      2:       return ((x + y) % 2) == 0;
      3:       return x < y;
      4:       return (x == H - 1) && (y == V - 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic build_model(input int kind);
    mtot = 0;
    for (int i = 0; i < V; i++) mrow[i] = 0;
    for (int i = 0; i < H; i++) mcol[i] = 0;
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        if (pat(kind, xx, yy)) begin
          mrow[yy]++;
          mcol[xx]++;
          mtot++;
        end
  endtask

  task automatic drive_frame(input int kind, input int n_lines, input int tail_px,
                             input bit fall_last, input bit poke_start);
    fval = 1'b1;
    dval = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < n_lines; l++) begin
      for (int xx = 0; xx < H; xx++) begin
        dval  = 1'b1;
        pixel = pat(kind, xx, l);
        start = poke_start && (l == 5) && (xx == 3);
        if (fall_last && (l == n_lines - 1) && (xx == H - 1)) fval = 1'b0;
        tick();
      end
      start = 1'b0;
      dval  = 1'b0;
      if (!(fall_last && (l == n_lines - 1))) repeat (4) tick();
    end
    for (int xx = 0; xx < tail_px; xx++) begin
      dval  = 1'b1;
      pixel = pat(kind, xx, n_lines);
      tick();
    end
    dval  = 1'b0;
    fval  = 1'b0;
    pixel = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) tick();
    chk("done_reached", 0, done, 1);
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start    = 1'b0;
    row_addr = '0;
    col_addr = '0;
    tick();
    chk("busy_read_zero_row", 0, row_cnt, 0);
    chk("busy_read_zero_col", 0, col_cnt, 0);
    for (int i = 0; i < 200 && state != 3'd3; i++) tick();
    chk("armed_wait_rise", 0, state, 3);
  endtask

  task automatic sweep();
    for (int a = 0; a < H + 2; a++) begin
      row_addr = 9'(a);
      col_addr = 10'(a);
      tick();
      chk("row_cnt", a, row_cnt, (a < V) ? mrow[a] : 0);
      chk("col_cnt", a, col_cnt, (a < H) ? mcol[a] : 0);
    end
    chk("total", 0, total, mtot);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    tab_full[0] = '{0,   0,    32, 24};
    tab_full[1] = '{23,  31,   32, 24};
    tab_full[2] = '{12,  16,   32, 24};
    tab_full[3] = '{24,  32,   0,  0};
    tab_full[4] = '{511, 1023, 0,  0};
    tab_short[0] = '{0,  0,    32, 11};
    tab_short[1] = '{9,  15,   32, 11};
    tab_short[2] = '{10, 16,   16, 10};
    tab_short[3] = '{11, 31,   0,  10};
    tab_short[4] = '{23, 32,   0,  0};
    tab_short[5] = '{24, 1023, 0,  0};

    rst = 1'b1; start = 1'b0; fval = 1'b0; dval = 1'b0; pixel = 1'b0;
    row_addr = '0; col_addr = '0;
    repeat (3) tick();
    chk("rst_row_cnt", 0, row_cnt, 0);
    chk("rst_col_cnt", 0, col_cnt, 0);
    chk("rst_total", 0, total, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_short", 0, short_f, 0);
    chk("rst_state", 0, state, 0);
    rst = 1'b0;
    tick();

    // Start timing: CLEAR holds exactly H cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", 0, state, 1);
    chk("start_busy", 0, busy, 1);
    chk("start_done", 0, done, 0);
    bad = 0;
    for (int i = 1; i < H; i++) begin
      tick();
      if (state != 3'd1 || busy != 1'b1 || done != 1'b0) bad++;
    end
    chk("clear_hold_cycles_bad", 0, bad, 0);
    tick();
    chk("clear_exit_state", 0, state, 2);
    chk("wait_low_busy", 0, busy, 1);
    tick();
    chk("wait_rise_state", 0, state, 3);

    // All-foreground frame, with an iSTART pulse mid-frame that must be ignored.
    drive_frame(0, V, 0, 1'b0, 1'b1);
    wait_done();
    chk("full_short", 0, short_f, 0);
    chk("full_total", 0, total, 768);
    chk("sat_total", 0, s_total, 768);
    for (int t = 0; t < 5; t++) begin
      row_addr = 9'(tab_full[t].row_addr);
      col_addr = 10'(tab_full[t].col_addr);
      tick();
      chk("full_row", t, row_cnt, tab_full[t].exp_row);
      chk("full_col", t, col_cnt, tab_full[t].exp_col);
      chk("sat_row", t, s_row, (tab_full[t].exp_row > 15) ? 15 : tab_full[t].exp_row);
      chk("sat_col", t, s_col, (tab_full[t].exp_col > 15) ? 15 : tab_full[t].exp_col);
    end

    // Single foreground pixel.
    arm();
    drive_frame(1, V, 0, 1'b0, 1'b0);
    wait_done();
    build_model(1);
    sweep();
    chk("single_short", 0, short_f, 0);

    // Arm in the middle of a frame: that frame must be skipped.
    fval = 1'b1;
    for (int l = 0; l < 6; l++) begin
      for (int xx = 0; xx < H; xx++) begin
        dval  = 1'b1;
        pixel = 1'b1;
        start = (l == 1) && (xx == 0);
        tick();
      end
      start = 1'b0;
      dval  = 1'b0;
      repeat (4) tick();
    end
    chk("midframe_wait_low", 0, state, 2);
    fval = 1'b0;
    repeat (3) tick();
    chk("midframe_wait_rise", 0, state, 3);
    drive_frame(3, V, 0, 1'b0, 1'b0);
    wait_done();
    build_model(3);
    sweep();

    // Frame ends after 10.5 lines.
    arm();
    drive_frame(0, 10, 16, 1'b0, 1'b0);
    wait_done();
    chk("short_flag", 0, short_f, 1);
    chk("short_total", 0, total, 336);
    for (int t = 0; t < 6; t++) begin
      row_addr = 9'(tab_short[t].row_addr);
      col_addr = 10'(tab_short[t].col_addr);
      tick();
      chk("short_row", t, row_cnt, tab_short[t].exp_row);
      chk("short_col", t, col_cnt, tab_short[t].exp_col);
    end

    // Asynchronous reset in the middle of accumulation, then a checkerboard run.
    arm();
    fval = 1'b1;
    repeat (2) tick();
    for (int xx = 0; xx < 40; xx++) begin
      dval  = 1'b1;
      pixel = 1'b1;
      tick();
    end
    dval = 1'b0;
    chk("accum_before_rst", 0, state, 4);
    rst = 1'b1;
    #1;
    chk("arst_state", 0, state, 0);
    chk("arst_busy", 0, busy, 0);
    chk("arst_done", 0, done, 0);
    chk("arst_total", 0, total, 0);
    chk("arst_short", 0, short_f, 0);
    chk("arst_row_cnt", 0, row_cnt, 0);
    chk("arst_col_cnt", 0, col_cnt, 0);
    repeat (2) tick();
    rst  = 1'b0;
    fval = 1'b0;
    tick();
    chk("idle_after_rst", 0, state, 0);
    arm();
    drive_frame(2, V, 0, 1'b0, 1'b0);
    wait_done();
    build_model(2);
    sweep();
    chk("checker_short", 0, short_f, 0);

    // Frame valid drops on the same cycle as the very last pixel.
    arm();
    drive_frame(4, V, 0, 1'b1, 1'b0);
    chk("last_px_done_n", 0, done, 0);
    tick();
    chk("last_px_done_n1", 0, done, 0);
    tick();
    chk("last_px_done_n2", 0, done, 1);
    chk("last_px_short", 0, short_f, 0);
    build_model(4);
    sweep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
